mpf_svc_gen_csr_mux: RTL and testbench

//  Routes one generic CSR request stream (index/rd/wr/data) from an MMIO manager to N_SLAVES MPF services.

---
 rtl/mpf_svc_csr_pkg.sv | 14 +
 rtl/mpf_svc_gen_csr_mux_if.sv | 16 +
 rtl/mpf_svc_csr_rd_tracker.sv | 78 +++++++
 rtl/mpf_svc_gen_csr_mux.sv | 68 ++++++
 tb/tb_mpf_svc_gen_csr_mux.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpf_svc_csr_pkg.sv
// mpf_svc_csr_pkg: shared DFH field layout, patch helper and read-tracker state encoding.
package mpf_svc_csr_pkg;
  localparam int DFH_NEXT_LO = 16;
  localparam int DFH_NEXT_HI = 39;
  localparam int DFH_EOL = 40;
  typedef enum logic [1:0] {IDLE, WAIT, RSP} t_csr_mux_state;
  function automatic logic [63:0] dfh_patch(input logic [63:0] data, input logic [23:0] next_bytes, input logic eol);
    logic [63:0] d;
    d = data;
    d[DFH_NEXT_HI:DFH_NEXT_LO] = next_bytes;
    d[DFH_EOL] = eol;
    return d;
  endfunction
endpackage

// File: rtl/mpf_svc_gen_csr_mux_if.sv
// mpf_svc_gen_csr_mux_if: manager-side CSR request/response bus.
interface mpf_svc_gen_csr_mux_if #(
  parameter int IDX_W = 6,
  parameter int N_DATA_BITS = 64
);
  logic [IDX_W-1:0] csr_req_idx;
  logic rd_req_en;
  logic wr_req_en;
  logic [N_DATA_BITS-1:0] wr_data;
  logic req_ready;
  logic rd_rsp_valid;
  logic [N_DATA_BITS-1:0] rd_data;
  logic rd_rsp_err;
  modport master(output csr_req_idx, rd_req_en, wr_req_en, wr_data, input req_ready, rd_rsp_valid, rd_data, rd_rsp_err);
  modport slave(input csr_req_idx, rd_req_en, wr_req_en, wr_data, output req_ready, rd_rsp_valid, rd_data, rd_rsp_err);
endinterface

// File: rtl/mpf_svc_csr_rd_tracker.sv
// mpf_svc_csr_rd_tracker: one outstanding read, timeout substitution and DFH chaining on capture.
module mpf_svc_csr_rd_tracker
  import mpf_svc_csr_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int N_ENTRIES = 16,
  parameter int N_DATA_BITS = 64,
  parameter int RD_TIMEOUT = 64,
  parameter int DFH_CHAIN = 1,
  parameter int SW = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rd_accept,
  input  logic rd_bad,
  input  logic rd_entry0,
  input  logic [SW-1:0] rd_slave,
  input  logic [N_SLAVES-1:0] s_rd_rsp_valid,
  input  logic [N_SLAVES*N_DATA_BITS-1:0] s_rd_data,
  input  logic [N_SLAVES*64-1:0] s_dfh_value,
  output logic idle,
  output logic rsp_valid,
  output logic rsp_err,
  output logic [N_DATA_BITS-1:0] rsp_data
);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam bit PATCH = DFH_CHAIN != 0 && N_DATA_BITS == 64;
  localparam logic [23:0] NEXT_BYTES = 24'(N_ENTRIES * 8);
  t_csr_mux_state state, state_nx;
  logic [TW-1:0] timer;
  logic [SW-1:0] id_q;
  logic e0_q, err_q, hit, expire, last;
  logic [N_DATA_BITS-1:0] data_q, cap;
  assign hit = s_rd_rsp_valid[id_q];
  assign expire = timer == TW'(RD_TIMEOUT - 1);
  assign last = 32'(id_q) == N_SLAVES - 1;
  // Entry 0 returns the slave's DFH with next-offset/EOL rewritten so the chain walks the mux windows.
  assign cap = PATCH && e0_q
    ? N_DATA_BITS'(dfh_patch(s_dfh_value[id_q*64 +: 64], last ? '0 : NEXT_BYTES, last))
    : s_rd_data[id_q*N_DATA_BITS +: N_DATA_BITS];
  always_comb begin
    state_nx = state;
    if (state == IDLE && rd_accept) state_nx = rd_bad ? RSP : WAIT;
    if (state == WAIT && (hit || expire)) state_nx = RSP;
    if (state == RSP) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
      id_q <= '0;
      e0_q <= 1'b0;
      err_q <= 1'b0;
      data_q <= '0;
    end else if (state == IDLE && rd_accept) begin
      timer <= '0;
      id_q <= rd_slave;
      e0_q <= rd_entry0 & ~rd_bad;
      err_q <= 1'b0;
      data_q <= '0;
    end else if (state == WAIT) begin
      timer <= timer == TW'(RD_TIMEOUT) ? timer : timer + TW'(1);
      if (hit) begin
        data_q <= cap;
        err_q <= 1'b0;
      end else if (expire) begin
        data_q <= '1;
        err_q <= 1'b1;
      end
    end
  end
  assign idle = state == IDLE;
  assign rsp_valid = state == RSP;
  assign rsp_err = rsp_valid & err_q;
  assign rsp_data = data_q;
endmodule

// File: rtl/mpf_svc_gen_csr_mux.sv
// mpf_svc_gen_csr_mux: decodes one CSR request stream onto N_SLAVES windows of N_ENTRIES registers.
module mpf_svc_gen_csr_mux
  import mpf_svc_csr_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int N_ENTRIES = 16,
  parameter int N_DATA_BITS = 64,
  parameter int RD_TIMEOUT = 64,
  parameter int DFH_CHAIN = 1
) (
  input  logic clk,
  input  logic reset_n,
  mpf_svc_gen_csr_mux_if.slave m,
  input  logic [N_SLAVES*64-1:0] s_dfh_value,
  output logic [$clog2(N_ENTRIES)-1:0] s_csr_req_idx,
  output logic [N_SLAVES-1:0] s_rd_req_en,
  output logic [N_SLAVES-1:0] s_wr_req_en,
  output logic [N_DATA_BITS-1:0] s_wr_data,
  input  logic [N_SLAVES-1:0] s_rd_rsp_valid,
  input  logic [N_SLAVES*N_DATA_BITS-1:0] s_rd_data,
  output logic protocol_err
);
  localparam int IW = $clog2(N_SLAVES * N_ENTRIES);
  localparam int LW = $clog2(N_ENTRIES);
  localparam int SW = IW > LW ? IW - LW : 1;
  logic [SW-1:0] sid;
  logic [N_SLAVES-1:0] sel;
  logic in_range, rd_acc, wr_acc;
  assign sid = SW'(m.csr_req_idx >> LW);
  assign in_range = 32'(sid) < N_SLAVES;
  // Out-of-range ids shift the strobe off the top, so such writes vanish naturally.
  assign sel = N_SLAVES'(1) << sid;
  assign rd_acc = m.req_ready & m.rd_req_en;
  assign wr_acc = m.req_ready & m.wr_req_en & ~m.rd_req_en;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_rd_req_en <= '0;
      s_wr_req_en <= '0;
      s_csr_req_idx <= '0;
      s_wr_data <= '0;
      protocol_err <= 1'b0;
    end else begin
      s_rd_req_en <= rd_acc && in_range ? sel : '0;
      s_wr_req_en <= wr_acc ? sel : '0;
      if (rd_acc | wr_acc) s_csr_req_idx <= m.csr_req_idx[LW-1:0];
      if (wr_acc) s_wr_data <= m.wr_data;
      if (rd_acc & m.wr_req_en) protocol_err <= 1'b1;
    end
  end
  mpf_svc_csr_rd_tracker #(
    .N_SLAVES(N_SLAVES), .N_ENTRIES(N_ENTRIES), .N_DATA_BITS(N_DATA_BITS),
    .RD_TIMEOUT(RD_TIMEOUT), .DFH_CHAIN(DFH_CHAIN), .SW(SW)
  ) u_trk (
    .clk(clk),
    .reset_n(reset_n),
    .rd_accept(rd_acc),
    .rd_bad(~in_range),
    .rd_entry0(m.csr_req_idx[LW-1:0] == '0),
    .rd_slave(sid),
    .s_rd_rsp_valid(s_rd_rsp_valid),
    .s_rd_data(s_rd_data),
    .s_dfh_value(s_dfh_value),
    .idle(m.req_ready),
    .rsp_valid(m.rd_rsp_valid),
    .rsp_err(m.rd_rsp_err),
    .rsp_data(m.rd_data)
  );
endmodule

// File: tb/tb_mpf_svc_gen_csr_mux.sv
// tb_mpf_svc_gen_csr_mux: directed scenarios plus random traffic against a response scoreboard.
module tb_mpf_svc_gen_csr_mux;
  localparam int NS = 4, NE = 16, DW = 64, TO = 64, IW = 6;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;
  mpf_svc_gen_csr_mux_if #(.IDX_W(IW), .N_DATA_BITS(DW)) m_if();
  logic [NS*64-1:0] s_dfh_value = '0;
  logic [3:0] s_csr_req_idx;
  logic [NS-1:0] s_rd_req_en, s_wr_req_en, s_rd_rsp_valid;
  logic [DW-1:0] s_wr_data;
  logic [NS*DW-1:0] s_rd_data;
  logic protocol_err;
  int errors = 0, checks = 0;
  int resp_delay = 1, cnt = 0, psl = 0;
  bit use_word = 0, noise = 0;
  logic [63:0] word = '0, pdata = '0;
  logic [31:0] salt = 32'h5EED_0001;
  typedef struct {logic [63:0] d; logic e;} exp_t;
  exp_t exp_q[$];

  mpf_svc_gen_csr_mux #(.N_SLAVES(NS), .N_ENTRIES(NE), .N_DATA_BITS(DW), .RD_TIMEOUT(TO), .DFH_CHAIN(1)) dut (
    .clk(clk), .reset_n(reset_n), .m(m_if), .s_dfh_value(s_dfh_value), .s_csr_req_idx(s_csr_req_idx),
    .s_rd_req_en(s_rd_req_en), .s_wr_req_en(s_wr_req_en), .s_wr_data(s_wr_data),
    .s_rd_rsp_valid(s_rd_rsp_valid), .s_rd_data(s_rd_data), .protocol_err(protocol_err)
  );

  function automatic logic [63:0] slave_word(int s, int l);
    return {salt, 8'(s), 8'(l), 16'hC5A3};
  endfunction
  function automatic logic [63:0] exp_read(int s, int l);
    logic [63:0] d;
    int last;
    if (l != 0) return slave_word(s, l);
    d = s_dfh_value[s*64 +: 64];
    last = (s == NS - 1) ? 1 : 0;
    return (d & ~(64'h1FF_FFFF << 16)) | (64'(last ? 0 : NE * 8) << 16) | (64'(last) << 40);
  endfunction

  // Slave model: answers the selected slave resp_delay cycles after its strobe, optional stray pulse elsewhere.
  initial begin
    s_rd_rsp_valid = '0;
    s_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      s_rd_rsp_valid = '0;
      for (int s = 0; s < NS; s++) s_rd_data[s*64 +: 64] = {32'hDEAD_0000, $urandom};
      if (!reset_n) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          s_rd_rsp_valid[psl] = 1'b1;
          s_rd_data[psl*64 +: 64] = pdata;
        end
      end
      if (reset_n && s_rd_req_en != '0) begin
        for (int s = 0; s < NS; s++) if (s_rd_req_en[s]) psl = s;
        pdata = use_word ? word : (s_csr_req_idx == 0 ? s_dfh_value[psl*64 +: 64] : slave_word(psl, int'(s_csr_req_idx)));
        cnt = resp_delay;
        if (noise) begin
          s_rd_rsp_valid[(psl+1)%NS] = 1'b1;
          s_rd_data[((psl+1)%NS)*64 +: 64] = ~pdata;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_bus;
    m_if.rd_req_en = 1'b0;
    m_if.wr_req_en = 1'b0;
  endtask
  task automatic drive(input bit rd, input bit wr, input int idx, input logic [63:0] d);
    m_if.rd_req_en = rd;
    m_if.wr_req_en = wr;
    m_if.csr_req_idx = IW'(idx);
    m_if.wr_data = d;
  endtask
  task automatic wait_rsp(output int n);
    n = 1;
    while (!m_if.rd_rsp_valid && n < 200) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    idle_bus;
    m_if.csr_req_idx = '0;
    m_if.wr_data = '0;
    #1 reset_n = 1'b0;
    repeat (3) tick;
    checks++;
    if ({m_if.req_ready, m_if.rd_rsp_valid, m_if.rd_rsp_err, protocol_err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 1000", {m_if.req_ready, m_if.rd_rsp_valid, m_if.rd_rsp_err, protocol_err});
    end
    checks++;
    if ({s_rd_req_en, s_wr_req_en, s_csr_req_idx} !== 12'h0 || s_wr_data !== '0 || m_if.rd_data !== '0) begin
      errors++;
      $display("FAIL reset_data: strobes/idx %h wdata %h rdata %h want 0", {s_rd_req_en, s_wr_req_en, s_csr_req_idx}, s_wr_data, m_if.rd_data);
    end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_write;
    logic [63:0] d;
    int idx;
    drive(0, 1, NE + 3, 64'hA5);
    tick;
    idle_bus;
    checks++;
    if ({s_wr_req_en, s_rd_req_en} !== 8'b0010_0000) begin
      errors++;
      $display("FAIL wr_strobe: got %b want 00100000", {s_wr_req_en, s_rd_req_en});
    end
    checks++;
    if (s_csr_req_idx !== 4'd3 || s_wr_data !== 64'hA5 || m_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_payload: idx %0d data %h ready %b want 3 a5 1", s_csr_req_idx, s_wr_data, m_if.req_ready);
    end
    tick;
    checks++;
    if (s_wr_req_en !== 4'b0) begin
      errors++;
      $display("FAIL wr_one_cycle: got %b want 0000", s_wr_req_en);
    end
    for (int i = 0; i < 12; i++) begin
      idx = $urandom_range(0, NS * NE - 1);
      d = {$urandom, $urandom};
      drive(0, 1, idx, d);
      tick;
      checks++;
      if (s_wr_req_en !== 4'(1 << (idx / NE)) || s_csr_req_idx !== 4'(idx % NE) || s_wr_data !== d || m_if.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL wr_b2b: en %b idx %0d data %h want en %b idx %0d data %h", s_wr_req_en, s_csr_req_idx, s_wr_data, 4'(1 << (idx / NE)), idx % NE, d);
      end
    end
    idle_bus;
    tick;
  endtask

  task automatic test_read;
    use_word = 1;
    word = 64'h1234;
    resp_delay = 1;
    drive(1, 0, 2, '0);
    tick;
    idle_bus;
    checks++;
    if (m_if.req_ready !== 1'b0 || s_rd_req_en !== 4'b0001 || s_csr_req_idx !== 4'd2 || m_if.rd_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_t1: ready %b en %b idx %0d valid %b want 0 0001 2 0", m_if.req_ready, s_rd_req_en, s_csr_req_idx, m_if.rd_rsp_valid);
    end
    tick;
    checks++;
    if (m_if.req_ready !== 1'b0 || m_if.rd_rsp_valid !== 1'b0 || s_rd_req_en !== 4'b0) begin
      errors++;
      $display("FAIL rd_t2: ready %b valid %b en %b want 0 0 0000", m_if.req_ready, m_if.rd_rsp_valid, s_rd_req_en);
    end
    tick;
    checks++;
    if (m_if.rd_rsp_valid !== 1'b1 || m_if.rd_data !== 64'h1234 || m_if.rd_rsp_err !== 1'b0 || m_if.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rd_t3: valid %b data %h err %b ready %b want 1 1234 0 0", m_if.rd_rsp_valid, m_if.rd_data, m_if.rd_rsp_err, m_if.req_ready);
    end
    tick;
    checks++;
    if (m_if.rd_rsp_valid !== 1'b0 || m_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_t4: valid %b ready %b want 0 1", m_if.rd_rsp_valid, m_if.req_ready);
    end
    use_word = 0;
  endtask

  task automatic test_timeout;
    int n, late;
    resp_delay = TO + 6;
    drive(1, 0, 2 * NE, '0);
    tick;
    idle_bus;
    checks++;
    if (s_rd_req_en !== 4'b0100) begin
      errors++;
      $display("FAIL to_strobe: got %b want 0100", s_rd_req_en);
    end
    wait_rsp(n);
    checks++;
    if (n != TO + 1 || m_if.rd_data !== '1 || m_if.rd_rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL to_rsp: cycles %0d data %h err %b want %0d all-ones 1", n, m_if.rd_data, m_if.rd_rsp_err, TO + 1);
    end
    late = 0;
    repeat (20) begin
      tick;
      late += int'(m_if.rd_rsp_valid);
    end
    checks++;
    if (late != 0 || m_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL to_late: extra rsps %0d ready %b want 0 1", late, m_if.req_ready);
    end
    resp_delay = TO - 1;
    drive(1, 0, 2 * NE + 5, '0);
    tick;
    idle_bus;
    wait_rsp(n);
    checks++;
    if (n != TO + 1 || m_if.rd_data !== slave_word(2, 5) || m_if.rd_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL to_tie: cycles %0d data %h err %b want %0d %h 0", n, m_if.rd_data, m_if.rd_rsp_err, TO + 1, slave_word(2, 5));
    end
    tick;
  endtask

  task automatic test_dfh;
    int n;
    logic [24:0] f;
    resp_delay = 1;
    s_dfh_value = '0;
    for (int s = 0; s < NS; s += NS - 1) begin
      drive(1, 0, s * NE, '0);
      tick;
      idle_bus;
      wait_rsp(n);
      f = m_if.rd_data[40:16];
      checks++;
      if (m_if.rd_rsp_valid !== 1'b1 || f !== (s == NS - 1 ? 25'h100_0000 : 25'h80)) begin
        errors++;
        $display("FAIL dfh_slave%0d: valid %b eol/next %h want %h", s, m_if.rd_rsp_valid, f, s == NS - 1 ? 25'h100_0000 : 25'h80);
      end
      tick;
    end
    s_dfh_value = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    drive(1, 0, NE, '0);
    tick;
    idle_bus;
    wait_rsp(n);
    checks++;
    if (m_if.rd_data !== exp_read(1, 0) || m_if.rd_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL dfh_keep: got %h want %h", m_if.rd_data, exp_read(1, 0));
    end
    tick;
  endtask

  task automatic test_proto;
    int n;
    resp_delay = 2;
    drive(1, 1, 5, 64'hFFFF);
    tick;
    idle_bus;
    checks++;
    if (s_rd_req_en !== 4'b0001 || s_wr_req_en !== 4'b0 || protocol_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_req: rd %b wr %b perr %b want 0001 0000 1", s_rd_req_en, s_wr_req_en, protocol_err);
    end
    wait_rsp(n);
    checks++;
    if (m_if.rd_data !== slave_word(0, 5) || protocol_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_hold: data %h perr %b want %h 1", m_if.rd_data, protocol_err, slave_word(0, 5));
    end
    tick;
  endtask

  task automatic test_midreset;
    int late;
    resp_delay = 1000;
    drive(1, 0, 17, '0);
    tick;
    idle_bus;
    repeat (3) tick;
    reset_n = 1'b0;
    #1;
    checks++;
    if (m_if.req_ready !== 1'b1 || m_if.rd_rsp_valid !== 1'b0 || protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset: ready %b valid %b perr %b want 1 0 0", m_if.req_ready, m_if.rd_rsp_valid, protocol_err);
    end
    tick;
    reset_n = 1'b1;
    late = 0;
    repeat (100) begin
      tick;
      late += int'(m_if.rd_rsp_valid);
    end
    checks++;
    if (late != 0 || m_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_drop: rsps %0d ready %b want 0 1", late, m_if.req_ready);
    end
  endtask

  task automatic test_back_to_back;
    int issued = 0, cyc = 0, kind, idx, r, d;
    logic [63:0] wd;
    exp_t e;
    noise = 1;
    salt = $urandom;
    while ((issued < 150 || exp_q.size() != 0) && cyc < 20000) begin
      kind = 0;
      idx = $urandom_range(0, NS * NE - 1);
      wd = {$urandom, $urandom};
      if (issued < 150 && m_if.req_ready) begin
        r = $urandom_range(0, 9);
        kind = r < 4 ? 1 : (r < 8 ? 2 : 0);
      end
      if (kind == 1) begin
        d = ($urandom_range(0, 24) == 0) ? TO + 10 : $urandom_range(1, 4);
        resp_delay = d;
        e.e = d >= TO;
        e.d = e.e ? '1 : exp_read(idx / NE, idx % NE);
        exp_q.push_back(e);
      end
      if (kind != 0) issued++;
      drive(kind == 1, kind == 2, idx, wd);
      tick;
      idle_bus;
      cyc++;
      checks++;
      if (s_rd_req_en !== (kind == 1 ? 4'(1 << (idx / NE)) : 4'b0) || s_wr_req_en !== (kind == 2 ? 4'(1 << (idx / NE)) : 4'b0)
          || (kind != 0 && s_csr_req_idx !== 4'(idx % NE)) || (kind == 2 && s_wr_data !== wd)) begin
        errors++;
        $display("FAIL rnd_req: kind %0d idx %0d rd %b wr %b lidx %0d wdata %h", kind, idx, s_rd_req_en, s_wr_req_en, s_csr_req_idx, s_wr_data);
      end
      if (m_if.rd_rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra: unexpected rsp data %h err %b", m_if.rd_data, m_if.rd_rsp_err);
        end else begin
          e = exp_q.pop_front();
          if (m_if.rd_data !== e.d || m_if.rd_rsp_err !== e.e) begin
            errors++;
            $display("FAIL rnd_rsp: got %h/%b want %h/%b", m_if.rd_data, m_if.rd_rsp_err, e.d, e.e);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || issued < 150) begin
      errors++;
      $display("FAIL rnd_missing: %0d reads unanswered, %0d issued of 150", exp_q.size(), issued);
    end
    noise = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_write;
    test_read;
    test_timeout;
    test_dfh;
    test_proto;
    test_midreset;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
